// File: rtl/time_display_driver_pkg.sv
// Shared definitions for the time display driver: FSM states, digit positions
// and the active-high 7-segment encoder.
package time_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CONV_CYCLES = 3'd7;

  localparam logic [2:0] SEC_ONES = 3'd0;
  localparam logic [2:0] SEC_TENS = 3'd1;
  localparam logic [2:0] MIN_ONES = 3'd2;
  localparam logic [2:0] MIN_TENS = 3'd3;
  localparam logic [2:0] HR_ONES  = 3'd4;
  localparam logic [2:0] HR_TENS  = 3'd5;

  localparam logic [6:0] SEG_DASH = 7'h40;

  // {g,f,e,d,c,b,a}; digits above 9 only occur for out-of-range fields, which are dashed
  function automatic logic [6:0] seg_code(input logic [3:0] d, input logic dash);
    logic [6:0] code;
    if (dash) begin
      code = SEG_DASH;
    end else begin
      case (d)
        4'd0:    code = 7'h3F;
        4'd1:    code = 7'h06;
        4'd2:    code = 7'h5B;
        4'd3:    code = 7'h4F;
        4'd4:    code = 7'h66;
        4'd5:    code = 7'h6D;
        4'd6:    code = 7'h7D;
        4'd7:    code = 7'h07;
        4'd8:    code = 7'h7F;
        4'd9:    code = 7'h6F;
        default: code = 7'h00;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/time_display_driver_bin2bcd_seq.sv
// One 7-bit sequential double-dabble field: start loads the binary value,
// each step applies add-3 correction then shifts one bit into the BCD nibbles.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [14:0] sr_r;
  logic [14:0] adj_s;
  logic [14:0] nxt_s;

  // add-3 correction of both BCD nibbles followed by the one-bit shift
  always_comb begin
    adj_s = sr_r;
    if (sr_r[10:7] >= 4'd5) begin
      adj_s[10:7] = sr_r[10:7] + 4'd3;
    end else begin
      adj_s[10:7] = sr_r[10:7];
    end
    if (sr_r[14:11] >= 4'd5) begin
      adj_s[14:11] = sr_r[14:11] + 4'd3;
    end else begin
      adj_s[14:11] = sr_r[14:11];
    end
    nxt_s = adj_s << 1;
  end

  // shift register holding {tens, ones, remaining binary bits}
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_r <= 15'd0;
    end else if (start) begin
      sr_r <= {8'd0, bin};
    end else if (step) begin
      sr_r <= nxt_s;
    end else begin
      sr_r <= sr_r;
    end
  end

  // Outputs show the result of the step taken this cycle, so the parent can
  // commit on the final conversion edge without an extra cycle.
  assign tens = nxt_s[14:11];
  assign ones = nxt_s[10:7];

endmodule

// File: rtl/time_display_driver.sv
// Samples binary hr/min/sec, converts to BCD and scans a 6-digit 7-segment display.
// Optional COLON_BLINK_EN: separator dp lit only while the committed seconds value is even.
module time_display_driver #(
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] hr,
  input  logic [6:0] min,
  input  logic [6:0] sec,
  input  logic       load,
  output logic       busy,
  output logic       bcd_valid,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  import time_disp_pkg::*;

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_RST = SEG_ACTIVE_LOW ? ~seg_code(4'd0, 1'b0) : seg_code(4'd0, 1'b0);

  state_t         state_r;
  logic [2:0]     cnt_r;
  logic [2:0]     pend_bad_r, bad_r, bad_nxt_s;   // {hr, min, sec}
  logic [5:0][3:0] dig_r, dig_nxt_s;
  logic [PW-1:0]  presc_r, presc_nxt_s;
  logic [2:0]     idx_r, idx_nxt_s;
  logic           busy_r, valid_r, dp_r, dp_on_s, dash_s;
  logic [5:0]     an_r;
  logic [6:0]     seg_r, code_s;
  logic [3:0]     digit_s;
  logic           start_s, step_s, commit_s;
  logic [3:0]     hr_t_s, hr_o_s, min_t_s, min_o_s, sec_t_s, sec_o_s;

  assign start_s  = (state_r == IDLE) && load;
  assign step_s   = (state_r == CONV);
  assign commit_s = step_s && (cnt_r == (CONV_CYCLES - 3'd1));

  bin2bcd_seq u_hr  (.clk(clk), .reset(reset), .start(start_s), .step(step_s),
                     .bin({1'b0, hr}), .tens(hr_t_s), .ones(hr_o_s));
  bin2bcd_seq u_min (.clk(clk), .reset(reset), .start(start_s), .step(step_s),
                     .bin(min), .tens(min_t_s), .ones(min_o_s));
  bin2bcd_seq u_sec (.clk(clk), .reset(reset), .start(start_s), .step(step_s),
                     .bin(sec), .tens(sec_t_s), .ones(sec_o_s));

  // next committed digits and scan position; seg/dp are built from these so they move with an
  always_comb begin
    if (commit_s) begin
      dig_nxt_s = {hr_t_s, hr_o_s, min_t_s, min_o_s, sec_t_s, sec_o_s};
      bad_nxt_s = pend_bad_r;
    end else begin
      dig_nxt_s = dig_r;
      bad_nxt_s = bad_r;
    end
    if (presc_r == PRESC_LAST) begin
      presc_nxt_s = PW'(0);
      idx_nxt_s   = (idx_r == HR_TENS) ? SEC_ONES : (idx_r + 3'd1);
    end else begin
      presc_nxt_s = presc_r + PW'(1);
      idx_nxt_s   = idx_r;
    end
    digit_s = dig_nxt_s[idx_nxt_s];
    dash_s  = bad_nxt_s[idx_nxt_s[2:1]];
    code_s  = seg_code(digit_s, dash_s);
`ifdef COLON_BLINK_EN
    dp_on_s = ((idx_nxt_s == MIN_ONES) || (idx_nxt_s == HR_ONES))
              && !bad_nxt_s[0] && !dig_nxt_s[SEC_ONES][0];
`else
    dp_on_s = (idx_nxt_s == MIN_ONES) || (idx_nxt_s == HR_ONES);
`endif
  end

  // conversion sequencer: capture on load, 7 shift cycles, one-cycle commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      pend_bad_r <= 3'd0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          if (load) begin
            state_r    <= CONV;
            cnt_r      <= 3'd0;
            busy_r     <= 1'b1;
            pend_bad_r <= {hr > 6'd23, min > 7'd59, sec > 7'd59};
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        CONV: begin
          if (cnt_r == (CONV_CYCLES - 3'd1)) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            valid_r <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + 3'd1;
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 3'd0;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  // committed digits, free-running scanner and registered pin drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig_r   <= 24'd0;
      bad_r   <= 3'd0;
      presc_r <= PW'(0);
      idx_r   <= SEC_ONES;
      an_r    <= 6'b000001;
      seg_r   <= SEG_RST;
      dp_r    <= SEG_ACTIVE_LOW;
    end else begin
      dig_r   <= dig_nxt_s;
      bad_r   <= bad_nxt_s;
      presc_r <= presc_nxt_s;
      idx_r   <= idx_nxt_s;
      an_r    <= 6'b000001 << idx_nxt_s;
      seg_r   <= SEG_ACTIVE_LOW ? ~code_s : code_s;
      dp_r    <= dp_on_s ^ SEG_ACTIVE_LOW;
    end
  end

  assign busy      = busy_r;
  assign bcd_valid = valid_r;
  assign an        = an_r;
  assign seg       = seg_r;
  assign dp        = dp_r;

endmodule

// File: tb/tb_time_display_driver.sv
// Randomized bench for time_display_driver, checked every cycle against a
// timeline/arithmetic reference model of the conversion and the scan.
module tb_time_display_driver;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [5:0] hr = 6'd0;
  logic [6:0] min = 7'd0;
  logic [6:0] sec = 7'd0;
  logic       busy, bcd_valid, dp;
  logic [5:0] an;
  logic [6:0] seg;

  int   n_checks = 0;
  int   n_fail = 0;
  logic chk_en = 1'b0;

  logic [6:0] seg_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  time_display_driver #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .hr(hr), .min(min), .sec(sec), .load(load),
    .busy(busy), .bcd_valid(bcd_valid), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: k = edges since reset; a load accepted at edge e gives
  // busy after edges e..e+6, bcd_valid and new values after edge e+7,
  // and the next load can be accepted from edge e+9.
  int   k, acc_e;
  int   pend_h, pend_m, pend_s, com_h, com_m, com_s;
  logic exp_busy, exp_valid;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k <= 0; acc_e <= -100;
      com_h <= 0; com_m <= 0; com_s <= 0;
      pend_h <= 0; pend_m <= 0; pend_s <= 0;
      exp_busy <= 1'b0; exp_valid <= 1'b0;
    end else begin
      if (load && (k > acc_e + 8)) begin
        acc_e <= k;
        pend_h <= int'(hr); pend_m <= int'(min); pend_s <= int'(sec);
        exp_busy <= 1'b1;
      end else begin
        exp_busy <= (k >= acc_e + 1) && (k <= acc_e + 6);
      end
      exp_valid <= (k == acc_e + 7);
      if (k == acc_e + 7) begin
        com_h <= pend_h; com_m <= pend_m; com_s <= pend_s;
      end
      k <= k + 1;
    end
  end

  function automatic logic [6:0] exp_seg(input int idx);
    int v, lim, d;
    case (idx / 2)
      0:       begin v = com_s; lim = 59; end
      1:       begin v = com_m; lim = 59; end
      default: begin v = com_h; lim = 23; end
    endcase
    d = (idx % 2 == 1) ? (v / 10) : (v % 10);
    if (v > lim) return ~7'h40;
    return ~seg_tbl[d];
  endfunction

  function automatic logic exp_dp(input int idx);
    logic on;
    on = (idx == 2) || (idx == 4);
`ifdef COLON_BLINK_EN
    on = on && (com_s <= 59) && (com_s % 2 == 0);
`endif
    return ~on;
  endfunction

  always @(negedge clk) begin : cyc_chk
    int idx;
    logic [5:0] exp_an;
    if (!reset && chk_en) begin
      idx = (k / SCAN_DIV) % 6;
      exp_an = 6'b000001 << idx;
      check_eq("busy", busy, exp_busy);
      check_eq("bcd_valid", bcd_valid, exp_valid);
      check_eq("an", an, exp_an);
      check_eq("seg", seg, exp_seg(idx));
      check_eq("dp", dp, exp_dp(idx));
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic pulse_load(input int h, input int m, input int s);
    hr = 6'(h); min = 7'(m); sec = 7'(s);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pulses, h, m, s;
    logic [6:0] seg_zero;
    seg_zero = 7'h40;   // ~7'h3F in 7 bits
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    check_eq("rst_an", an, 6'b000001);
    check_eq("rst_seg", seg, seg_zero);
    check_eq("rst_dp", dp, 1'b1);
    check_eq("rst_busy", busy, 1'b0);

    pulses = 0;
    repeat (20) begin tick(); if (bcd_valid) pulses++; end
    check_eq("idle_pulses", pulses, 0);

    // 23:59:58 latency and display
    pulse_load(23, 59, 58);
    n = 1;
    while (!bcd_valid && n < 20) begin tick(); n++; end
    check_eq("latency", n, 8);
    repeat (30) tick();

    // minutes out of range -> dashes
    pulse_load(7, 60, 33);
    repeat (40) tick();

    // second load during conversion is dropped
    pulse_load(12, 34, 12);
    repeat (2) tick();
    pulse_load(5, 6, 1);
    pulses = 0;
    repeat (20) begin tick(); if (bcd_valid) pulses++; end
    check_eq("one_valid", pulses, 1);
    repeat (10) tick();

    // reset in the 4th conversion cycle
    pulse_load(11, 22, 33);
    repeat (3) tick();
    check_eq("mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_valid", bcd_valid, 1'b0);
    check_eq("abort_an", an, 6'b000001);
    check_eq("abort_seg", seg, seg_zero);
    tick();
    reset = 1'b0;
    pulses = 0;
    repeat (30) begin tick(); if (bcd_valid) pulses++; end
    check_eq("abort_pulses", pulses, 0);

    // randomized loads, some out of range, some landing during conversion
    repeat (80) begin
      h = ($urandom_range(0, 3) == 0) ? $urandom_range(24, 63) : $urandom_range(0, 23);
      m = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 127) : $urandom_range(0, 59);
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 127) : $urandom_range(0, 59);
      pulse_load(h, m, s);
      repeat ($urandom_range(0, 14)) tick();
    end
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
